// File: rtl/pucch_re_mapper.sv
// PUCCH fmt0/1 RE mapper: ping-pong sample banks, full-slot RE stream out.
// Optional intra-slot hopping enabled by defining PUCCH_MAP_FREQ_HOP_EN.
module pucch_re_mapper #(
    parameter int N_PRB = 4,
    parameter int N_SYM = 14,
    parameter int DW    = 16,
    parameter int PW    = (N_PRB > 1) ? $clog2(N_PRB) : 1,
    parameter int SW    = $clog2(12 * N_PRB)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [2:0]           i_pucch_format,
    input  logic [3:0]           i_symStart,
    input  logic [3:0]           i_nPUCCHSym,
    input  logic [PW-1:0]        i_prb_start,
    input  logic [PW-1:0]        i_prb_second,
    input  logic signed [DW-1:0] i_re,
    input  logic signed [DW-1:0] i_im,
    input  logic                 i_valid,
    output logic signed [DW-1:0] o_re,
    output logic signed [DW-1:0] o_im,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [3:0]           o_sym,
    output logic [SW-1:0]        o_sc,
    output logic                 o_dmrs,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic                 o_busy
);
    localparam int N_SC = 12 * N_PRB;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

    state_t r_state, w_next;

    logic [2:0]           r_fmt;
    logic [3:0]           r_ss, r_ns;
    logic [PW-1:0]        r_p0, r_p1;
    logic [3:0]           r_nsym;
    logic [SW-1:0]        r_nsc;
    logic                 r_more;
    logic                 r_valid, r_odmrs, r_olast;
    logic signed [DW-1:0] r_ore, r_oim;
    logic [3:0]           r_osym;
    logic [SW-1:0]        r_osc;
    logic                 r_wbank, r_rbank, r_ovf;
    logic [3:0]           r_wptr;
    logic [1:0]           r_full;
    logic signed [DW-1:0] r_mre [2][12];
    logic signed [DW-1:0] r_mim [2][12];

    logic [4:0]    w_r;
    logic          w_act, w_data, w_dmrs, w_place;
    logic [PW-1:0] w_prb;
    logic [SW-1:0] w_base, w_off;
    logic [3:0]    w_idx;
    logic          w_hs, w_free, w_rb, w_stall, w_load, w_last_hs, w_wr;

    // Classify the next RE to be loaded into the output register
    assign w_r    = {1'b0, r_nsym} - {1'b0, r_ss};
    assign w_act  = (r_nsym >= r_ss) && (w_r < {1'b0, r_ns});
    assign w_data = w_act && ((r_fmt == 3'd0) || ((r_fmt == 3'd1) && w_r[0]));
    assign w_dmrs = w_act && (r_fmt == 3'd1) && !w_r[0];

`ifdef PUCCH_MAP_FREQ_HOP_EN
    assign w_prb = (w_r < {2'b00, r_ns[3:1]}) ? r_p0 : r_p1;
`else
    logic w_unused;
    assign w_unused = ^{i_prb_second, r_p1};
    assign w_prb = r_p0;
`endif

    assign w_base  = SW'(12) * SW'(w_prb);
    assign w_off   = r_nsc - w_base;
    assign w_idx   = w_off[3:0];
    assign w_place = w_data && (r_nsc >= w_base) && (w_off < SW'(12));

    assign w_hs      = r_valid && i_ready;
    assign w_free    = w_hs && r_olast;
    // A bank freed this cycle hands reads over to the other bank immediately
    assign w_rb      = r_rbank ^ w_free;
    assign w_stall   = w_place && !r_full[w_rb];
    assign w_load    = (r_state == S_RUN) && r_more && (!r_valid || i_ready) && !w_stall;
    assign w_last_hs = w_hs && (r_osym == 4'(N_SYM - 1)) && (r_osc == SW'(N_SC - 1));
    assign w_wr      = i_valid && !r_full[r_wbank];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN: begin
                if (w_last_hs)            w_next = S_DONE;
                else if (r_more && w_stall) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_last_hs)         w_next = S_DONE;
                else if (r_full[w_rb]) w_next = S_RUN;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fmt   <= '0;
            r_ss    <= '0;
            r_ns    <= '0;
            r_p0    <= '0;
            r_p1    <= '0;
            r_nsym  <= '0;
            r_nsc   <= '0;
            r_more  <= 1'b0;
            r_valid <= 1'b0;
            r_ore   <= '0;
            r_oim   <= '0;
            r_osym  <= '0;
            r_osc   <= '0;
            r_odmrs <= 1'b0;
            r_olast <= 1'b0;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_wptr  <= '0;
            r_full  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start) begin
                r_fmt  <= i_pucch_format;
                r_ss   <= i_symStart;
                r_ns   <= i_nPUCCHSym;
                r_p0   <= i_prb_start;
                r_p1   <= i_prb_second;
                r_nsym <= '0;
                r_nsc  <= '0;
                r_more <= 1'b1;
                r_ovf  <= 1'b0;
            end
            if (w_hs) r_valid <= 1'b0;
            if (w_load) begin
                r_valid <= 1'b1;
                r_ore   <= w_place ? r_mre[w_rb][w_idx] : '0;
                r_oim   <= w_place ? r_mim[w_rb][w_idx] : '0;
                r_osym  <= r_nsym;
                r_osc   <= r_nsc;
                r_odmrs <= w_dmrs;
                r_olast <= w_place && (w_idx == 4'd11);
                if (r_nsc == SW'(N_SC - 1)) begin
                    r_nsc <= '0;
                    if (r_nsym == 4'(N_SYM - 1)) r_more <= 1'b0;
                    else                         r_nsym <= r_nsym + 4'd1;
                end else begin
                    r_nsc <= r_nsc + SW'(1);
                end
            end
            if (w_free) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= ~r_rbank;
            end
            if (i_valid && r_full[r_wbank]) r_ovf <= 1'b1;
            if (w_wr) begin
                if (r_wptr == 4'd11) begin
                    r_wptr          <= '0;
                    r_full[r_wbank] <= 1'b1;
                    r_wbank         <= ~r_wbank;
                end else begin
                    r_wptr <= r_wptr + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mre[r_wbank][r_wptr] <= i_re;
            r_mim[r_wbank][r_wptr] <= i_im;
        end
    end

    assign o_re       = r_ore;
    assign o_im       = r_oim;
    assign o_valid    = r_valid;
    assign o_sym      = r_osym;
    assign o_sc       = r_osc;
    assign o_dmrs     = r_odmrs;
    assign o_done     = (r_state == S_DONE);
    assign o_busy     = (r_state == S_RUN) || (r_state == S_WAIT);
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_pucch_re_mapper.sv
// Scoreboard bench for pucch_re_mapper: full-slot RE order, placement,
// stalls, overflow, mid-slot reset and (with PUCCH_MAP_FREQ_HOP_EN) hopping.
module tb_pucch_re_mapper;
    localparam int N_PRB = 4;
    localparam int N_SYM = 14;
    localparam int DW    = 16;
    localparam int PW    = 2;
    localparam int SW    = 6;
    localparam int N_SC  = 48;

    logic clk = 1'b0;
    logic rst;
    logic i_start;
    logic [2:0] i_pucch_format;
    logic [3:0] i_symStart, i_nPUCCHSym;
    logic [PW-1:0] i_prb_start, i_prb_second;
    logic signed [DW-1:0] i_re, i_im, o_re, o_im;
    logic i_valid, o_valid, i_ready;
    logic [3:0] o_sym;
    logic [SW-1:0] o_sc;
    logic o_dmrs, o_done, o_overflow, o_busy;

    always #5 clk = ~clk;

    pucch_re_mapper #(.N_PRB(N_PRB), .N_SYM(N_SYM), .DW(DW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_pucch_format(i_pucch_format), .i_symStart(i_symStart),
        .i_nPUCCHSym(i_nPUCCHSym), .i_prb_start(i_prb_start),
        .i_prb_second(i_prb_second), .i_re(i_re), .i_im(i_im),
        .i_valid(i_valid), .o_re(o_re), .o_im(o_im), .o_valid(o_valid),
        .i_ready(i_ready), .o_sym(o_sym), .o_sc(o_sc), .o_dmrs(o_dmrs),
        .o_done(o_done), .o_overflow(o_overflow), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [3:0]  sym;
        logic [5:0]  sc;
        logic        dmrs;
        logic [15:0] re;
        logic [15:0] im;
        logic        dat;
    } exp_t;

    exp_t exp_q[$];
    int n_run = 0;
    int n_fail = 0;
    logic [15:0] s_re[96];
    logic [15:0] s_im[96];
    logic [2:0] c_fmt;
    logic [3:0] c_ss, c_ns;
    logic [1:0] c_p0, c_p1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int f, input int ss, input int ns,
                           input int p0, input int p1);
        c_fmt = 3'(f);
        c_ss  = 4'(ss);
        c_ns  = 4'(ns);
        c_p0  = 2'(p0);
        c_p1  = 2'(p1);
        for (int i = 0; i < 96; i++) begin
            s_re[i] = 16'($urandom);
            s_im[i] = 16'($urandom);
        end
    endtask

    function automatic void build_exp();
        int j;
        int r;
        int prb;
        bit act, dat, dm;
        exp_t e;
        j = 0;
        exp_q.delete();
        for (int l = 0; l < N_SYM; l++) begin
            r   = l - int'(c_ss);
            act = (r >= 0) && (r < int'(c_ns));
            dat = act && (c_fmt == 0 || (c_fmt == 1 && r % 2 == 1));
            dm  = act && c_fmt == 1 && r % 2 == 0;
            prb = int'(c_p0);
`ifdef PUCCH_MAP_FREQ_HOP_EN
            if (r >= int'(c_ns) / 2) prb = int'(c_p1);
`endif
            for (int k = 0; k < N_SC; k++) begin
                e.sym  = 4'(l);
                e.sc   = 6'(k);
                e.dmrs = dm;
                e.re   = '0;
                e.im   = '0;
                e.dat  = 1'b0;
                if (dat && k >= 12 * prb && k < 12 * prb + 12) begin
                    e.re  = s_re[12 * j + k - 12 * prb];
                    e.im  = s_im[12 * j + k - 12 * prb];
                    e.dat = 1'b1;
                end
                exp_q.push_back(e);
            end
            if (dat) j++;
        end
    endfunction

    task automatic run_slot(input string nm, input int nsamp, input bit rnd,
                            input bit ovf, input int rst_sym, input bit lat);
        int n, cons, hs, dcnt, last_cyc, ovf_st, ovf_cyc;
        bit stall, rst_pend, done;
        logic [42:0] held;
        exp_t e;
        n = 0; cons = 0; hs = 0; dcnt = 0; last_cyc = -1;
        ovf_st = 0; ovf_cyc = 0;
        stall = 0; rst_pend = 0; done = 0; held = '0;
        build_exp();
        @(negedge clk);
        i_start        = 1'b1;
        i_pucch_format = c_fmt;
        i_symStart     = c_ss;
        i_nPUCCHSym    = c_ns;
        i_prb_start    = c_p0;
        i_prb_second   = c_p1;
        i_valid        = 1'b0;
        i_ready        = 1'b1;
        for (int cyc = 1; cyc < 6000 && !done; cyc++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (cyc == 100 && rst_sym < 0) begin
                i_start        = 1'b1;
                i_pucch_format = 3'd0;
                i_symStart     = 4'd0;
                i_nPUCCHSym    = 4'd2;
                i_prb_start    = 2'd3;
            end
            if (rst_pend) begin
                rst = 1'b1;
                i_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check({nm, "_rst_valid"}, 64'(o_valid), 64'd0);
                check({nm, "_rst_busy"}, 64'(o_busy), 64'd0);
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (o_done) dcnt++;
                end
                check({nm, "_rst_nodone"}, 64'(dcnt), 64'd0);
                done = 1;
            end else begin
                if (ovf && ovf_st < 2) i_ready = 1'b0;
                else i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                i_valid = 1'b0;
                if (ovf && ovf_st == 0 && n == 24 && cyc % 3 == 0) begin
                    i_valid = 1'b1;
                    i_re    = 16'h1234;
                    i_im    = 16'h5678;
                    ovf_st  = 1;
                    ovf_cyc = cyc;
                end else if (n < nsamp && cyc % 3 == 0 &&
                             (n < 24 || cons >= 12 * (n / 12 - 1)) &&
                             !(ovf && ovf_st == 0 && n >= 24)) begin
                    i_valid = 1'b1;
                    i_re    = s_re[n];
                    i_im    = s_im[n];
                    n++;
                end
                #1;
                if (ovf_st == 1 && cyc == ovf_cyc)
                    check({nm, "_ovf_pre"}, 64'(o_overflow), 64'd0);
                if (ovf_st == 1 && cyc == ovf_cyc + 1) begin
                    check({nm, "_ovf_set"}, 64'(o_overflow), 64'd1);
                    ovf_st = 2;
                end
                if (lat && cyc == 1) check({nm, "_lat1"}, 64'(o_valid), 64'd0);
                if (lat && cyc == 2) check({nm, "_lat2"}, 64'(o_valid), 64'd1);
                if (stall)
                    check({nm, "_hold"}, 64'({o_sym, o_sc, o_dmrs, o_re, o_im}),
                          64'(held));
                stall = o_valid && !i_ready;
                held  = {o_sym, o_sc, o_dmrs, o_re, o_im};
                if (o_done) dcnt++;
                if (o_valid && i_ready) begin
                    hs++;
                    if (exp_q.size() == 0) begin
                        check({nm, "_extra_re"}, 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("%s_s%0d_k%0d", nm, e.sym, e.sc),
                              64'({o_sym, o_sc, o_dmrs, o_re, o_im}),
                              64'({e.sym, e.sc, e.dmrs, e.re, e.im}));
                        if (e.dat) cons++;
                    end
                    if (rst_sym >= 0 && int'(o_sym) == rst_sym && o_sc == 0)
                        rst_pend = 1;
                    if (o_sym == 4'd13 && o_sc == 6'd47) last_cyc = cyc;
                end
                if (last_cyc > 0 && cyc == last_cyc + 1) begin
                    check({nm, "_done"}, 64'(o_done), 64'd1);
                    check({nm, "_busy_low"}, 64'(o_busy), 64'd0);
                end
                if (last_cyc > 0 && cyc == last_cyc + 2) done = 1;
            end
        end
        if (!done) check({nm, "_timeout"}, 64'd0, 64'd1);
        if (rst_sym < 0) begin
            check({nm, "_hs_cnt"}, 64'(hs), 64'd672);
            check({nm, "_done_cnt"}, 64'(dcnt), 64'd1);
            check({nm, "_ovf_end"}, 64'(o_overflow), 64'(ovf));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_pucch_format = '0;
        i_symStart = '0;
        i_nPUCCHSym = '0;
        i_prb_start = '0;
        i_prb_second = '0;
        i_re = '0;
        i_im = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_ovf", 64'(o_overflow), 64'd0);
        check("reset_data", 64'({o_re, o_im, o_sym, o_sc, o_dmrs}), 64'd0);

        set_cfg(1, 4, 7, 1, 1);
        s_re[0] = 16'h0000;
        s_im[0] = 16'h7FFF;
        run_slot("t1", 36, 0, 0, -1, 1);

        set_cfg(0, 4, 2, 0, 0);
        s_re[0] = 16'(-23170);
        s_im[0] = 16'(-23170);
        run_slot("t2", 24, 0, 0, -1, 1);

        set_cfg(1, 4, 7, 1, 1);
        s_re[0] = 16'h0000;
        s_im[0] = 16'h7FFF;
        run_slot("t3", 36, 1, 0, -1, 1);

        set_cfg(1, 4, 7, 1, 1);
        run_slot("t4", 36, 0, 1, -1, 0);

        set_cfg(1, 4, 7, 2, 2);
        run_slot("t5", 36, 0, 0, 7, 0);
        set_cfg(0, 4, 2, 3, 3);
        run_slot("t5b", 24, 0, 0, -1, 1);

        set_cfg(2, 0, 4, 1, 1);
        run_slot("fmt2", 0, 0, 0, -1, 1);

        set_cfg(0, 12, 4, 2, 2);
        run_slot("trunc", 24, 1, 0, -1, 1);

`ifdef PUCCH_MAP_FREQ_HOP_EN
        set_cfg(1, 4, 7, 0, 3);
        run_slot("t6", 36, 0, 0, -1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
